// File: rtl/ram_1024x9_rd_stream.sv
// Read-side sequencer for the 1024x9 sample buffer.
// Streams a wrapped run of words onto a valid/ready port via a skid FIFO.
module ram_1024x9_rd_stream #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 9,
    parameter int LEN_WIDTH  = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  rd_len,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2**ADDR_WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, state_nx;
    logic [LEN_WIDTH-1:0]  len_clamp;
    logic [LEN_WIDTH-1:0]  issue_left;
    logic [LEN_WIDTH-1:0]  out_left;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  v1, v2;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           fifo_count;
    logic [PW+1:0]         credit;
    logic                  accept, issue, push, pop;

    assign len_clamp = (rd_len > MAX_LEN) ? MAX_LEN : rd_len;
    assign accept    = (state == IDLE) && start && (len_clamp != '0);
    assign credit    = {1'b0, fifo_count} + (PW+2)'(v1) + (PW+2)'(v2);
    assign issue     = accept ||
                       ((state == RUN) && (issue_left != '0) &&
                        (credit < (PW+2)'(FIFO_DEPTH)));
    assign push      = v2;
    assign m_valid   = (fifo_count != '0);
    assign pop       = m_valid && m_ready;
    assign m_data    = m_valid ? mem[rd_ptr] : '0;
    assign m_last    = m_valid && (out_left == LEN_WIDTH'(1));
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // State register
    always_ff @(posedge rd_clk) begin
        if (rd_rst) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: run until all issued, drain until last handshake
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (len_clamp != '0) ? RUN : DONE;
            end
            RUN: begin
                if (issue_left == '0) state_nx = DRAIN;
            end
            DRAIN: begin
                if (pop && (out_left == LEN_WIDTH'(1))) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read issue, in-flight tracking and FIFO bookkeeping
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            ram_rd_addr <= '0;
            next_addr   <= '0;
            issue_left  <= '0;
            out_left    <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
        end else begin
            if (accept) begin
                ram_rd_addr <= start_addr;
                next_addr   <= start_addr + ADDR_WIDTH'(1);
                issue_left  <= len_clamp - LEN_WIDTH'(1);
            end else if (issue) begin
                ram_rd_addr <= next_addr;
                next_addr   <= next_addr + ADDR_WIDTH'(1);
                issue_left  <= issue_left - LEN_WIDTH'(1);
            end
            if (accept)   out_left <= len_clamp;
            else if (pop) out_left <= out_left - LEN_WIDTH'(1);
            v1 <= issue;
            v2 <= v1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // FIFO storage; contents are don't-care until pushed
    always_ff @(posedge rd_clk) begin
        if (push) mem[wr_ptr] <= ram_rd_data;
    end

endmodule

// File: tb/tb_ram_1024x9_rd_stream.sv
// Bench for ram_1024x9_rd_stream.
// Scoreboard of expected words built from address/length arithmetic.
module tb_ram_1024x9_rd_stream;

    logic       rd_clk = 0;
    logic       rd_rst = 1;
    logic       start = 0;
    logic [9:0] start_addr = 0;
    logic [10:0] rd_len = 0;
    logic [9:0] ram_rd_addr;
    logic [8:0] ram_rd_data = 0;
    logic [8:0] m_data;
    logic       m_valid;
    logic       m_ready = 1;
    logic       m_last;
    logic       busy;
    logic       done;

    ram_1024x9_rd_stream dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .start(start),
        .start_addr(start_addr), .rd_len(rd_len),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .done(done)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct { int d; int l; } ent_t;

    logic [8:0] ram [1024];
    ent_t exp_q[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, t0 = 0, exp_n = 0, xfer_cnt = 0;
    int   done_due = -1;
    bit   ready_rand = 0;
    bit   prev_stall = 0;

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(posedge rd_clk) cyc <= cyc + 1;

    // Synchronous-read buffer model, one cycle latency
    always @(posedge rd_clk) ram_rd_data <= ram[ram_rd_addr];

    always @(posedge rd_clk) begin
        #1;
        m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Per-cycle compare against the scoreboard
    always @(negedge rd_clk) begin
        if (rd_rst) begin
            prev_stall = 0;
        end else begin
            chk("done", int'(done), int'(cyc == done_due));
            chk("fifo_bound", int'(dut.fifo_count <= 4), 1);
            if (prev_stall) chk("hold_valid", int'(m_valid), 1);
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("m_data", int'(m_data), exp_q[0].d);
                    chk("m_last", int'(m_last), exp_q[0].l);
                    if (m_ready) begin
                        if (exp_q[0].l != 0) done_due = cyc + 1;
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
        end
    end

    task automatic launch(int addr, int len);
        int n;
        @(posedge rd_clk); #1;
        start = 1; start_addr = 10'(addr); rd_len = 11'(len);
        t0 = cyc;
        n = (len > 1024) ? 1024 : len;
        exp_n = n;
        xfer_cnt = 0;
        for (int k = 0; k < n; k++)
            exp_q.push_back('{int'(ram[(addr + k) % 1024]), int'(k == n - 1)});
        if (n == 0) done_due = t0 + 1;
        @(posedge rd_clk); #1;
        start = 0;
    endtask

    task automatic wait_done(int bound);
        int n = 0;
        bit seen = 0;
        while (!seen && n < bound) begin
            @(negedge rd_clk); #1;
            seen = done;
            n++;
        end
        chk("done_seen", int'(seen), 1);
        chk("xfer_count", xfer_cnt, exp_n);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 9'(i);
        repeat (3) @(posedge rd_clk);
        #1 rd_rst = 0;
        @(negedge rd_clk);
        chk("rst_addr", int'(ram_rd_addr), 0);
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_data", int'(m_data), 0);

        // Short run, literal timing
        launch(5, 4);
        @(negedge rd_clk);
        chk("t1_addr", int'(ram_rd_addr), 5);
        chk("t1_busy", int'(busy), 1);
        @(negedge rd_clk);
        chk("t1_no_valid_c2", int'(m_valid), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge rd_clk);
            chk("t1_valid", int'(m_valid), 1);
            chk("t1_data", int'(m_data), 5 + i);
            chk("t1_last", int'(m_last), int'(i == 3));
        end
        @(negedge rd_clk);
        chk("t1_done", int'(done), 1);
        chk("t1_done_cycle", cyc - t0, 7);

        // Wrap around the top of the buffer
        launch(1022, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge rd_clk);
            case (i)
                0: chk("t2_addr", int'(ram_rd_addr), 1022);
                1: chk("t2_addr", int'(ram_rd_addr), 1023);
                2: begin
                    chk("t2_addr", int'(ram_rd_addr), 0);
                    chk("t2_data", int'(m_data), 510);
                end
                default: begin
                    chk("t2_addr", int'(ram_rd_addr), 1);
                    chk("t2_data", int'(m_data), 511);
                end
            endcase
        end
        wait_done(50);

        // Full-depth run under random backpressure
        ready_rand = 1;
        launch(int'($urandom_range(0, 1023)), 1024);
        wait_done(20000);
        ready_rand = 0;

        // Zero length and over-length
        launch(7, 0);
        @(negedge rd_clk);
        chk("t4_done_c1", int'(done), 1);
        chk("t4_no_valid", int'(m_valid), 0);
        launch(33, 2000);
        wait_done(3000);
        chk("t4_clamp", xfer_cnt, 1024);

        // Reset mid-run
        launch(100, 64);
        for (int i = 0; i < 200 && xfer_cnt < 10; i++) begin
            @(posedge rd_clk); #1;
        end
        chk("t5_reached10", xfer_cnt, 10);
        rd_rst = 1;
        @(posedge rd_clk); #1;
        rd_rst = 0;
        exp_q.delete();
        done_due = -1;
        @(negedge rd_clk);
        chk("t5_rst_addr", int'(ram_rd_addr), 0);
        chk("t5_rst_valid", int'(m_valid), 0);
        chk("t5_rst_last", int'(m_last), 0);
        chk("t5_rst_data", int'(m_data), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_done", int'(done), 0);
        repeat (6) @(negedge rd_clk);
        ready_rand = 1;
        launch(900, 6);
        wait_done(200);

        // Start while busy is ignored
        launch(200, 20);
        repeat (3) @(negedge rd_clk);
        chk("t6_busy", int'(busy), 1);
        @(posedge rd_clk); #1;
        start = 1; start_addr = 0; rd_len = 5;
        @(posedge rd_clk); #1;
        start = 0;
        wait_done(500);
        ready_rand = 0;
        repeat (8) @(negedge rd_clk);
        chk("t6_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_1024x9_rd_stream.md
Name: ram_1024x9_rd_stream

Overview:
- Read-side sequencer for the 1024x9 simple dual-port sample buffer (non-registered output, 1-cycle read latency). Software or an upstream FSM writes audio sample frames into the buffer.
- On a start pulse, this block reads a run of words from a start address with modulo-1024 wrap. It presents them on a valid/ready stream with a last marker, sustaining full throughput under backpressure.
- It sits between the buffer's read port and the downstream audio processing pipeline, in the read-clock domain.

Parameters:
ADDR_WIDTH, 10, buffer address width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 9, buffer word width
LEN_WIDTH, 11, width of rd_len (ADDR_WIDTH+1, so the full depth is expressible)
FIFO_DEPTH, 4, output skid FIFO entries (power of two, >= 4)

Ports:
rd_clk  input  1  read clock; only clock of the block
rd_rst  input  1  synchronous active-high reset
start  input  1  one-cycle request; sampled only when busy=0
start_addr  input  ADDR_WIDTH  first word address
rd_len  input  LEN_WIDTH  number of words to read
ram_rd_addr  output  ADDR_WIDTH  to buffer rd_addr
ram_rd_data  input  DATA_WIDTH  from buffer rd_data; valid one rd_clk after address
m_data  output  DATA_WIDTH  stream data
m_valid  output  1  stream valid
m_ready  input  1  stream ready
m_last  output  1  marks final word of run
busy  output  1  run in progress
done  output  1  one-cycle pulse at run completion

Behaviour:
- Interface is fixed: a single clock, rd_clk. Reset rd_rst is synchronous and active-high.
- Reset values (the cycle after rd_rst is sampled high): ram_rd_addr=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0. FIFO and all counters are cleared.
- Reset mid-run aborts the run. No further words are output and done does not pulse.
- FSM states and transitions:
  - IDLE -> RUN on start with clamped rd_len != 0.
  - IDLE -> DONE on start with rd_len == 0.
  - RUN -> DRAIN when all words are issued.
  - DRAIN -> DONE when the last word is handshaken.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
- busy=1 in RUN, DRAIN and DONE. start is ignored while busy=1.
- rd_len is clamped to 1024 when greater than 1024. The length and address are latched at start.
- Issue rule: in RUN, a read issues when (fifo_count + reads_in_flight) < FIFO_DEPTH.
  - reads_in_flight counts issued reads not yet written to the FIFO; max 2.
  - Each issue loads ram_rd_addr and decrements the remaining count.
  - The address increments modulo 2**ADDR_WIDTH: 1023 wraps to 0.
- Pipeline timing, first word:
  - start sampled high in cycle 0.
  - ram_rd_addr = start_addr during cycle 1.
  - ram_rd_data valid in cycle 2 and written to the FIFO at the end of cycle 2.
  - m_valid=1 from cycle 3.
  - Total start-to-first-valid latency: 3 cycles.
- Throughput: with m_ready held 1, one word per cycle with no bubbles.
- ram_rd_addr holds its value when no read is issued.
- Stream rules:
  - A transfer occurs when m_valid & m_ready.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a transfer.
  - m_last=1 only with the final word of the run.
- Backpressure: issue stalls when credits are exhausted. The FIFO never overflows or underflows; the bench asserts this.
- done pulses in the cycle after the final transfer. The next start is accepted in the cycle after done.

Test Plan:
- Buffer preloaded with word[i]=i[8:0]; start_addr=5, rd_len=4, m_ready=1 -> m_valid from cycle 3; m_data 5,6,7,8 on consecutive cycles; m_last on 8; done the cycle after the last transfer.
- start_addr=1022, rd_len=4 -> ram_rd_addr sequence 1022,1023,0,1; m_data 1022[8:0],1023[8:0],0,1.
- rd_len=1024, m_ready toggled randomly at 50% -> exactly 1024 transfers, in order, with no duplicates; stability holds under stall; the FIFO never overflows.
- rd_len=0 -> done pulses in cycle 1 with no m_valid; rd_len=2000 -> exactly 1024 words.
- rd_rst asserted after 10 of 64 words -> all outputs reach reset values the next cycle; no done; a new start afterwards streams correctly from its own start_addr.
- start pulsed again while busy -> ignored; the original run completes unchanged.
